arbitro_registro16: RTL

Write arbiter and sequencer for the shared 16-bit register (Registro16Bit). Up to NUM_SOL requesters present a data word with a 4-phase request/acknowledge handshake. The arbiter selects one requester, latches its word onto Tupla and pulses Habilitar for exactly one clock so the register captures it. It then acknowledges the winner and waits for the winner's request to drop. Sits between the datapath units and the register's Tupla/Habilitar inputs.

---
 rtl/arbitro_registro16.sv | 122 ++++++++++++
 1 files changed

// File: rtl/arbitro_registro16.sv
// Purpose: write arbiter and sequencer that feeds Tupla/Habilitar of the shared 16-bit register.
// Latency: 1 edge from request to Habilitar, 2 edges to Ack, 4 cycles minimum between grants.
// Backpressure: 4-phase req/ack; losers and late requests stay pending, no pre-emption.
// Option: define ARB_ROUND_ROBIN_EN for round-robin selection; default build uses fixed priority.
module arbitro_registro16 #(
   parameter int NUM_SOL = 4,
   parameter int ANCHO   = 16
) (
   input  logic                     Reloj,
   input  logic                     Reiniciar,
   input  logic [NUM_SOL-1:0]       Solicitud,
   input  logic [ANCHO*NUM_SOL-1:0] Datos,
   output logic [ANCHO-1:0]         Tupla,
   output logic                     Habilitar,
   output logic [NUM_SOL-1:0]       Concesion,
   output logic [NUM_SOL-1:0]       Ack,
   output logic                     Ocupado
);

   localparam int PW = (NUM_SOL > 1) ? $clog2(NUM_SOL) : 1;

   typedef enum logic [1:0] {
      REPOSO   = 2'b00,
      ESCRIBIR = 2'b01,
      ESPERA   = 2'b10
   } estado_t;

   estado_t       r_estado;
   logic [PW-1:0] r_ganador;
   logic          w_hay;
   logic [PW-1:0] w_ganador;

   // Lowest set bit of a request vector; the caller guarantees at least one bit is set.
   function automatic logic [PW-1:0] f_primero(input logic [NUM_SOL-1:0] v);
      logic [PW-1:0] idx;
      idx = '0;
      for (int k = NUM_SOL - 1; k >= 0; k--) begin
         if (v[k]) idx = PW'(k);
      end
      return idx;
   endfunction

`ifdef ARB_ROUND_ROBIN_EN
   logic [PW-1:0]      r_puntero;
   logic [NUM_SOL-1:0] w_alto;

   // Round-robin pick: requests at or above the pointer win first, otherwise wrap to the lowest.
   always_comb begin
      w_alto = '0;
      for (int k = 0; k < NUM_SOL; k++) begin
         w_alto[k] = Solicitud[k] & (PW'(k) >= r_puntero);
      end
      w_hay     = |Solicitud;
      w_ganador = (|w_alto) ? f_primero(w_alto) : f_primero(Solicitud);
   end

   // Pointer moves one past the winner each time a transaction completes.
   always_ff @(posedge Reloj) begin
      if (Reiniciar) begin
         r_puntero <= '0;
      end else if (r_estado == ESPERA && !Solicitud[r_ganador]) begin
         if (r_ganador == PW'(NUM_SOL - 1)) r_puntero <= '0;
         else                               r_puntero <= r_ganador + 1'b1;
      end
   end
`else
   // Fixed priority pick: the lowest requesting index wins.
   always_comb begin
      w_hay     = |Solicitud;
      w_ganador = f_primero(Solicitud);
   end
`endif

   // Handshake sequencer; every output is registered here so the register sees clean levels.
   always_ff @(posedge Reloj) begin
      if (Reiniciar) begin
         r_estado  <= REPOSO;
         r_ganador <= '0;
         Tupla     <= '0;
         Habilitar <= 1'b0;
         Concesion <= '0;
         Ack       <= '0;
         Ocupado   <= 1'b0;
      end else begin
         case (r_estado)
            REPOSO: begin
               if (w_hay) begin
                  r_ganador <= w_ganador;
                  Concesion <= NUM_SOL'(1) << w_ganador;
                  Tupla     <= Datos[ANCHO*w_ganador +: ANCHO];
                  Habilitar <= 1'b1;
                  Ocupado   <= 1'b1;
                  r_estado  <= ESCRIBIR;
               end
            end
            ESCRIBIR: begin
               // Register captures Tupla on this edge; requests are not looked at here.
               Habilitar <= 1'b0;
               Ack       <= NUM_SOL'(1) << r_ganador;
               r_estado  <= ESPERA;
            end
            ESPERA: begin
               if (!Solicitud[r_ganador]) begin
                  Ack       <= '0;
                  Concesion <= '0;
                  Ocupado   <= 1'b0;
                  r_estado  <= REPOSO;
               end
            end
            default: begin
               r_estado  <= REPOSO;
               Tupla     <= '0;
               Habilitar <= 1'b0;
               Concesion <= '0;
               Ack       <= '0;
               Ocupado   <= 1'b0;
            end
         endcase
      end
   end

endmodule
